// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial add/subtract controller.
// Latency: n/a (constants, types and a width helper only).
// Backpressure: n/a.
package serial_adder_defs;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int WIDTH_MIN     = 1;
  localparam int WIDTH_MAX     = 32;
  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // One spare bit so the counter can never wrap inside an operation.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requester and the serial adder controller.
// Latency: n/a (wiring only).
// Backpressure: none; start is only honoured while the controller is idle.
interface serial_adder_ctrl_if
  import serial_adder_defs::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, op_a, op_b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, op_a, op_b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder_ctrl_fa.sv
// Single-bit full adder cell.
// Latency: combinational.
// Backpressure: n/a.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller driving one full_adder cell, LSB first.
// Latency: WIDTH clocks from accepted start to done; one op per WIDTH+2 clocks.
// Backpressure: start is sampled only in IDLE; requests in RUN/DONE are dropped.
module serial_adder_ctrl
  import serial_adder_defs::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;
  logic             fa_sum;
  logic             fa_cout;
  logic             last;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last = (cnt == CW'(WIDTH - 1));

  // Result enters at the MSB so after WIDTH shifts bit 0 sits at bit 0.
  always_comb begin
    r_nxt            = r_sh >> 1;
    r_nxt[WIDTH-1]   = fa_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_nxt == RUN);
      done_q <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            // Subtract is a + ~b + 1; the requester's cin is irrelevant then.
            a_sh  <= bus.op_a;
            b_sh  <= bus.sub ? ~bus.op_b : bus.op_b;
            carry <= bus.sub | bus.cin;
            r_sh  <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          r_sh  <= r_nxt;
          carry <= fa_cout;
          cnt   <= cnt + CW'(1);
          if (last) begin
            // On the MSB step, carry still holds the carry into the MSB.
            sum_q  <= r_nxt;
            cout_q <= fa_cout;
            ovf_q  <= carry ^ fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

  a_width_legal: assert property (@(posedge clk)
    (WIDTH >= WIDTH_MIN) && (WIDTH <= WIDTH_MAX));

  a_done_pulse: assert property (@(posedge clk) disable iff (rst)
    bus.done |=> !bus.done);

  a_busy_done_excl: assert property (@(posedge clk) disable iff (rst)
    !(bus.busy && bus.done));

  a_result_stable: assert property (@(posedge clk) disable iff (rst)
    (state != RUN || !last) |=> $stable(bus.sum) && $stable(bus.cout) && $stable(bus.ovf));

endmodule
